// File: rtl/fir_coef_loader.sv
// fir_coef_loader: streams a coefficient frame into a shadow bank
// and commits it to the live FIR coefficient bus on a sample strobe.
module fir_coef_loader #(
  parameter int NTAPS = 10,
  parameter int CW    = 8
) (
  input  logic                clk,
  input  logic                rst_p,
  input  logic                ena,
  input  logic                load_valid,
  input  logic [CW-1:0]       load_data,
  input  logic                load_last,
  output logic                load_ready,
  output logic [NTAPS*CW-1:0] coef_out,
  output logic                busy,
  output logic                commit,
  output logic                frame_err
);

  localparam int IW = $clog2(NTAPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_PEND
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nx;
  logic [IW-1:0]              r_idx;
  logic [IW-1:0]              w_idx_nx;
  logic [IW-1:0]              w_widx;
  logic [NTAPS-1:0][CW-1:0]   r_shadow;
  logic [NTAPS-1:0][CW-1:0]   r_coef;
  logic                       r_commit;
  logic                       r_err;
  logic                       w_commit_nx;
  logic                       w_err_nx;
  logic                       w_acc;
  logic                       w_wr;

  assign load_ready = (r_state != S_PEND);
  assign busy       = (r_state != S_IDLE);
  assign w_acc      = load_valid & load_ready;
  assign w_widx     = (r_state == S_IDLE) ? '0 : r_idx;
  assign coef_out   = r_coef;
  assign commit     = r_commit;
  assign frame_err  = r_err;

  // Next-state, word index and pulse decode from the registered state.
  always_comb begin
    w_state_nx  = r_state;
    w_idx_nx    = r_idx;
    w_commit_nx = 1'b0;
    w_err_nx    = 1'b0;
    w_wr        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_wr = 1'b1;
          if (load_last) begin
            w_err_nx = 1'b1;
            w_idx_nx = '0;
          end else begin
            w_idx_nx   = IW'(1);
            w_state_nx = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_acc) begin
          w_wr = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_idx_nx = '0;
            if (load_last) begin
              w_state_nx = S_PEND;
            end else begin
              w_err_nx   = 1'b1;
              w_state_nx = S_DRAIN;
            end
          end else if (load_last) begin
            w_idx_nx   = '0;
            w_err_nx   = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_idx_nx = r_idx + IW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (w_acc && load_last) begin
          w_state_nx = S_IDLE;
        end
      end
      S_PEND: begin
        if (ena) begin
          w_commit_nx = 1'b1;
          w_state_nx  = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_idx_nx   = '0;
      end
    endcase
  end

  // State, index and status pulse registers.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_commit <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_idx    <= w_idx_nx;
      r_commit <= w_commit_nx;
      r_err    <= w_err_nx;
    end
  end

  // Shadow bank collects incoming words by tap position.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      r_shadow <= '0;
    end else if (w_wr) begin
      r_shadow[w_widx] <= load_data;
    end
  end

  // Live set: identity after reset, whole shadow copied on commit.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      r_coef    <= '0;
      r_coef[0] <= CW'(1);
    end else if (w_commit_nx) begin
      r_coef <= r_shadow;
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb_fir_coef_loader: scoreboard bench for the coefficient loader,
// frame outcomes predicted from word counts and last flags.
module tb_fir_coef_loader;

  localparam int NTAPS = 10;
  localparam int CW    = 8;
  localparam int W     = NTAPS * CW;

  typedef logic [W-1:0] coef_t;

  logic          clk = 1'b0;
  logic          rst_p = 1'b1;
  logic          ena = 1'b0;
  logic          load_valid = 1'b0;
  logic [CW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          load_ready;
  coef_t         coef_out;
  logic          busy;
  logic          commit;
  logic          frame_err;

  always #5 clk = ~clk;

  fir_coef_loader #(.NTAPS(NTAPS), .CW(CW)) dut (
    .clk        (clk),
    .rst_p      (rst_p),
    .ena        (ena),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .coef_out   (coef_out),
    .busy       (busy),
    .commit     (commit),
    .frame_err  (frame_err)
  );

  int            vec = 0;
  int            mis = 0;
  coef_t         exp_commit[$];
  int            exp_err = 0;
  coef_t         mon_live;
  bit            mon_on = 1'b0;
  logic          prev_ena = 1'b0;
  int            ena_mode = 0;
  logic [CW-1:0] words[0:15];

  function automatic coef_t identity();
    coef_t v;
    v = '0;
    v[0] = 1'b1;
    return v;
  endfunction

  function automatic coef_t pack_words();
    coef_t v;
    v = '0;
    for (int k = 0; k < NTAPS; k++) v[k*CW +: CW] = words[k];
    return v;
  endfunction

  task automatic chk(input string nm, input coef_t act, input coef_t exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock step; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    case (ena_mode)
      0: ena = 1'b1;
      1: ena = 1'b0;
      2: ena = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  // Monitor: pops expectations whenever the DUT pulses commit/frame_err.
  always @(negedge clk) begin
    if (mon_on) begin
      if (commit === 1'b1) begin
        chk("commit_needs_ena", coef_t'(prev_ena), coef_t'(1));
        if (exp_commit.size() == 0)
          chk("unexpected_commit", coef_t'(commit), coef_t'(0));
        else
          mon_live = exp_commit.pop_front();
      end
      chk("coef_out", coef_out, mon_live);
      if (frame_err === 1'b1) begin
        if (exp_err == 0)
          chk("unexpected_frame_err", coef_t'(frame_err), coef_t'(0));
        else
          exp_err--;
      end
      prev_ena = ena;
      if (rst_p) begin
        mon_live = identity();
        exp_commit.delete();
        exp_err = 0;
      end
    end
  end

  // Sends words[0..n-1], last on the final one; predicts the outcome.
  task automatic send_frame(input int n, input int gap_pct,
                            input int rst_after);
    bit drain;
    bit acc;
    bit last;
    drain = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0)
        while ($urandom_range(0, 99) < gap_pct) tick();
      last       = (i == n - 1);
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = last;
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        @(negedge clk);
        acc = load_ready;
        tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      if (!acc) begin
        chk("accept_timeout", coef_t'(0), coef_t'(1));
        return;
      end
      if (!drain) begin
        if (i + 1 < NTAPS && last) begin
          exp_err++;
        end else if (i + 1 == NTAPS) begin
          if (last) begin
            exp_commit.push_back(pack_words());
          end else begin
            exp_err++;
            drain = 1'b1;
          end
        end
      end
      if (rst_after == i + 1) begin
        rst_p = 1'b1;
        tick();
        rst_p = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 300; t++) begin
      if (exp_commit.size() == 0 && exp_err == 0) break;
      tick();
    end
    if (exp_commit.size() != 0 || exp_err != 0) begin
      chk("drain_timeout", coef_t'(0), coef_t'(1));
      exp_commit.delete();
      exp_err = 0;
    end
    tick();
    tick();
  endtask

  initial begin
    int n;
    rst_p = 1'b1;
    repeat (3) tick();
    rst_p    = 1'b0;
    mon_live = identity();
    mon_on   = 1'b1;

    repeat (5) tick();
    @(negedge clk);
    chk("reset_coef", coef_out, identity());
    chk("reset_ready", coef_t'(load_ready), coef_t'(1));
    chk("reset_busy", coef_t'(busy), coef_t'(0));
    chk("reset_commit", coef_t'(commit), coef_t'(0));
    chk("reset_err", coef_t'(frame_err), coef_t'(0));
    tick();

    ena_mode = 0;
    for (int k = 0; k < NTAPS; k++) words[k] = CW'(k + 1);
    send_frame(NTAPS, 0, 0);
    @(negedge clk);
    chk("pend_ready", coef_t'(load_ready), coef_t'(0));
    chk("pend_busy", coef_t'(busy), coef_t'(1));
    tick();
    @(negedge clk);
    chk("commit_pulse", coef_t'(commit), coef_t'(1));
    chk("post_busy", coef_t'(busy), coef_t'(0));
    chk("post_ready", coef_t'(load_ready), coef_t'(1));
    tick();
    @(negedge clk);
    chk("commit_once", coef_t'(commit), coef_t'(0));
    tick();
    wait_drain();

    ena_mode = 1;
    tick();
    for (int k = 0; k < NTAPS; k++) words[k] = CW'(8'h20 + k);
    send_frame(NTAPS, 0, 0);
    load_valid = 1'b1;
    load_data  = 8'hAA;
    repeat (7) begin
      @(negedge clk);
      chk("pend_hold_ready", coef_t'(load_ready), coef_t'(0));
      tick();
    end
    load_valid = 1'b0;
    ena_mode = 3;
    ena = 1'b1;
    @(negedge clk);
    chk("no_early_commit", coef_t'(commit), coef_t'(0));
    tick();
    ena = 1'b0;
    @(negedge clk);
    chk("late_commit", coef_t'(commit), coef_t'(1));
    tick();
    ena_mode = 0;
    wait_drain();

    for (int k = 0; k < 4; k++) words[k] = CW'(8'h50 + k);
    send_frame(4, 0, 0);
    wait_drain();
    @(negedge clk);
    chk("short_busy", coef_t'(busy), coef_t'(0));
    tick();
    for (int k = 0; k < NTAPS; k++) words[k] = 8'hFD;
    send_frame(NTAPS, 0, 0);
    wait_drain();

    for (int k = 0; k < 13; k++) words[k] = CW'(8'h60 + k);
    send_frame(13, 0, 0);
    wait_drain();
    @(negedge clk);
    chk("long_busy", coef_t'(busy), coef_t'(0));
    chk("long_ready", coef_t'(load_ready), coef_t'(1));
    tick();

    ena_mode = 2;
    for (int k = 0; k < NTAPS; k++) words[k] = CW'($urandom);
    send_frame(NTAPS, 30, 6);
    tick();
    @(negedge clk);
    chk("rst_coef_identity", coef_out, identity());
    chk("rst_busy", coef_t'(busy), coef_t'(0));
    tick();
    for (int k = 0; k < NTAPS; k++) words[k] = CW'($urandom);
    send_frame(NTAPS, 30, 0);
    wait_drain();

    for (int f = 0; f < 25; f++) begin
      n = ($urandom_range(0, 1) == 1) ? NTAPS : $urandom_range(1, 13);
      for (int k = 0; k < 16; k++) words[k] = CW'($urandom);
      send_frame(n, 20, 0);
      wait_drain();
    end

    @(negedge clk);
    chk("end_busy", coef_t'(busy), coef_t'(0));
    chk("end_queue", coef_t'(exp_commit.size()), coef_t'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/fir_coef_loader.md
# fir_coef_loader

Streams a new coefficient set into the 10-tap FIR datapath over a valid/ready handshake and presents it on a flattened coefficient bus. Words land in a shadow bank and are committed to the live bus only on a sample-enable cycle, so the filter never runs with a half-updated set. The block sits between the control/host side and the coefficient input of the FIR filter and shares its clock, reset and `ena` sample strobe.

## Interface
- `NTAPS`, 10: number of coefficients; must be ≥2.
- `CW`, 8: coefficient width in bits, two's complement.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_p`  in  1  synchronous, active-high reset.
- `ena`  in  1  FIR sample strobe; a commit happens only on a cycle where `ena` is 1.
- `load_valid`  in  1  a load word is present.
- `load_data`  in  CW  signed coefficient word; the first word of a frame is tap 0.
- `load_last`  in  1  marks the final word of a frame.
- `load_ready`  out  1  the block accepts a word on this cycle.
- `coef_out`  out  NTAPS*CW  live coefficients; tap k occupies bits [CW*k+CW-1 : CW*k].
- `busy`  out  1  1 whenever the state is not IDLE.
- `commit`  out  1  one-cycle pulse when `coef_out` updates.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.

## Operation
- Transfer: a word is accepted when `load_valid` and `load_ready` are both 1. `load_data` and `load_last` are sampled only on accepted cycles.
- State machine:
  - IDLE (`load_ready`=1). An accepted word writes shadow[0] and sets `idx`=1, then goes to LOAD. If that first word has `load_last`=1, the frame is short: pulse `frame_err` and stay in IDLE.
  - LOAD (`load_ready`=1). An accepted word writes shadow[`idx`] and increments `idx`.
    - `load_last`=1 with `idx`==NTAPS-1: go to PEND.
    - `load_last`=1 with `idx`<NTAPS-1: short frame; pulse `frame_err`, go to IDLE.
    - `load_last`=0 with `idx`==NTAPS-1: long frame; pulse `frame_err`, go to DRAIN.
  - DRAIN (`load_ready`=1). Accepted words are discarded. An accepted word with `load_last`=1 returns the block to IDLE. No further `frame_err` is raised.
  - PEND (`load_ready`=0). On a cycle with `ena`=1: copy shadow to `coef_out`, pulse `commit`, go to IDLE.
- `load_ready` is decoded from the registered state only; it has no combinational path from inputs.
- A rejected frame never modifies `coef_out`. The shadow contents after a rejection are don't-care.
- Coefficients pass through unmodified; there is no arithmetic and no width change.
- Reset values: state=IDLE, `idx`=0, `load_ready`=1 (the cycle after reset), `busy`=0, `commit`=0, `frame_err`=0.
  - `coef_out`: tap 0 = +1, all other taps = 0 (identity filter).
  - Shadow bank: cleared to 0.
- Reset during LOAD, DRAIN or PEND: the frame is lost, no `commit` is issued, and `coef_out` returns to the identity set.

## Timing
- Every output is registered or decoded from registered state; there is no input-to-output combinational path.
- Last word accepted on cycle N: state is PEND on N+1. If `ena`=1 on N+1, `coef_out` and `commit` update at the edge ending N+1 (earliest possible). Otherwise the commit slips to the first later `ena`=1 cycle.
- A commit edge is an edge on which the FIR also samples with `ena`. The FIR register updated at that edge uses the old set; the next sample uses the new set.
- `frame_err` is asserted in the cycle after the offending word is accepted.
- Minimum frame-to-frame spacing is NTAPS+1 cycles: NTAPS accepted words plus one PEND cycle with `ena`=1.
- `busy` rises the cycle after the first accepted word and falls the cycle after the commit or error resolves. It also covers DRAIN.

## Test plan
- Reset, then idle 5 cycles → `coef_out` = tap0 `8'h01`, other taps 0; `load_ready`=1; `busy`=0.
- Load words 1..10 back-to-back (last on word 10) with `ena`=1 continuously → PEND for one cycle; `commit` pulses once; `coef_out` tap k = k+1. No accepts occur while PEND.
- Same frame with `ena`=0 for 7 cycles after the last word, then a single `ena` pulse → `coef_out` unchanged until the edge of that `ena` cycle; `load_valid` held high during PEND sees `load_ready`=0.
- Short frame: 4 words, last on word 4 → `frame_err` pulses once; `coef_out` unchanged; the next full frame of 10× `-8'sd3` commits cleanly.
- Long frame: 13 words, last on word 13 → `frame_err` pulses once after word 10; words 11–13 are discarded; state returns to IDLE; `coef_out` unchanged.
- Random `load_valid` gaps, plus `rst_p` pulsed after word 6 of a frame → no `commit`; `coef_out` returns to identity; a subsequent full frame commits correctly.
